// File: rtl/servant_boot_ctrl_if.sv
// Bundle for the boot controller's byte-stream and Wishbone write port.
// The controller uses the master modport. The byte source and the RAM-side
// slave use the slave modport. Signal names follow the controller's view.
interface servant_boot_ctrl_if;
  logic [7:0]  i_rx_data;
  logic        i_rx_valid;
  logic        o_rx_ready;
  logic [31:0] o_wb_adr;
  logic [31:0] o_wb_dat;
  logic [3:0]  o_wb_sel;
  logic        o_wb_we;
  logic        o_wb_cyc;
  logic        i_wb_ack;

  modport master (
    input  i_rx_data, i_rx_valid, i_wb_ack,
    output o_rx_ready, o_wb_adr, o_wb_dat, o_wb_sel, o_wb_we, o_wb_cyc
  );

  modport slave (
    output i_rx_data, i_rx_valid, i_wb_ack,
    input  o_rx_ready, o_wb_adr, o_wb_dat, o_wb_sel, o_wb_we, o_wb_cyc
  );
endinterface

// File: rtl/servant_boot_ctrl.sv
// Boot sequencer for servant. It keeps the CPU in reset and receives a
// length-prefixed byte image. It packs the image into 32-bit words and writes
// them to RAM over Wishbone. After a fixed settle time it releases the CPU.
// All outputs come from registers. Each one is computed from the next state,
// so an output changes on the same edge as the state transition that causes it.
module servant_boot_ctrl #(
  parameter int memsize  = 8192,
  parameter int rst_hold = 64
) (
  input  logic                  wb_clk,
  input  logic                  wb_rst_n,
  servant_boot_ctrl_if.master   bus,
  output logic                  o_cpu_rst,
  output logic                  o_done,
  output logic                  o_err
);

  localparam int              AW        = $clog2(memsize);
  localparam logic [AW-1:0]   ADR_STEP  = AW'(4);
  localparam logic [31:0]     MEM_BYTES = 32'(memsize);
  localparam logic [15:0]     HOLD_LAST = 16'(rst_hold - 1);

  typedef enum logic [2:0] {
    S_LEN   = 3'd0,
    S_DATA  = 3'd1,
    S_WRITE = 3'd2,
    S_HOLD  = 3'd3,
    S_RUN   = 3'd4,
    S_ERR   = 3'd5
  } state_t;

  state_t          state_q, state_d;
  logic [31:0]     len_q, len_d;
  logic [31:0]     cnt_q, cnt_d;
  logic [AW-1:0]   adr_q, adr_d;
  logic [31:0]     dat_q, dat_d;
  logic [3:0]      sel_q, sel_d;
  logic [15:0]     hold_q, hold_d;
  logic            rx_ready_q, rx_ready_d;
  logic            cyc_q, cyc_d;
  logic            cpu_rst_q, cpu_rst_d;
  logic            done_q, done_d;
  logic            err_q, err_d;

  logic            rx_fire_s;
  logic            ack_s;
  logic [1:0]      lane_s;
  logic [32:0]     cnt_inc_s;

  // A byte moves only when the registered ready is high. An ack counts only in WRITE.
  assign rx_fire_s = bus.i_rx_valid & rx_ready_q;
  assign ack_s     = bus.i_wb_ack & (state_q == S_WRITE);
  assign lane_s    = cnt_q[1:0];
  assign cnt_inc_s = {1'b0, cnt_q} + 33'd1;

  // Next-state logic: length capture, word packing, write handshake, settle counter.
  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    adr_d   = adr_q;
    dat_d   = dat_q;
    sel_d   = sel_q;
    hold_d  = hold_q;

    case (state_q)
      S_LEN: begin
        if (rx_fire_s) begin
          len_d[{lane_s, 3'b000} +: 8] = bus.i_rx_data;
          if (lane_s == 2'd3) begin
            // The counter is reused from length bytes to image bytes.
            cnt_d  = 32'd0;
            hold_d = 16'd0;
            if (len_d == 32'd0) begin
              state_d = S_HOLD;
            end else if (len_d > MEM_BYTES) begin
              state_d = S_ERR;
            end else begin
              state_d = S_DATA;
            end
          end else begin
            cnt_d = cnt_inc_s[31:0];
          end
        end else begin
          state_d = S_LEN;
        end
      end

      S_DATA: begin
        if (rx_fire_s) begin
          dat_d[{lane_s, 3'b000} +: 8] = bus.i_rx_data;
          sel_d[lane_s]                = 1'b1;
          cnt_d                        = cnt_inc_s[31:0];
          if ((lane_s == 2'd3) || (cnt_inc_s == {1'b0, len_q})) begin
            state_d = S_WRITE;
          end else begin
            state_d = S_DATA;
          end
        end else begin
          state_d = S_DATA;
        end
      end

      S_WRITE: begin
        if (ack_s) begin
          adr_d  = adr_q + ADR_STEP;
          dat_d  = 32'd0;
          sel_d  = 4'd0;
          hold_d = 16'd0;
          if (cnt_q == len_q) begin
            state_d = S_HOLD;
          end else begin
            state_d = S_DATA;
          end
        end else begin
          state_d = S_WRITE;
        end
      end

      S_HOLD: begin
        if (hold_q == HOLD_LAST) begin
          state_d = S_RUN;
        end else begin
          hold_d = hold_q + 16'd1;
        end
      end

      S_RUN:   state_d = S_RUN;
      S_ERR:   state_d = S_ERR;
      default: state_d = S_ERR;
    endcase
  end

  // Registered outputs are derived from the state being entered.
  always_comb begin
    rx_ready_d = (state_d == S_LEN) || (state_d == S_DATA);
    cyc_d      = (state_d == S_WRITE);
    cpu_rst_d  = (state_d != S_RUN);
    done_d     = (state_d == S_RUN);
    err_d      = (state_d == S_ERR);
  end

  // State and output registers, with synchronous active-low reset.
  always_ff @(posedge wb_clk) begin
    if (!wb_rst_n) begin
      state_q    <= S_LEN;
      len_q      <= 32'd0;
      cnt_q      <= 32'd0;
      adr_q      <= '0;
      dat_q      <= 32'd0;
      sel_q      <= 4'd0;
      hold_q     <= 16'd0;
      rx_ready_q <= 1'b0;
      cyc_q      <= 1'b0;
      cpu_rst_q  <= 1'b1;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      cnt_q      <= cnt_d;
      adr_q      <= adr_d;
      dat_q      <= dat_d;
      sel_q      <= sel_d;
      hold_q     <= hold_d;
      rx_ready_q <= rx_ready_d;
      cyc_q      <= cyc_d;
      cpu_rst_q  <= cpu_rst_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign bus.o_rx_ready = rx_ready_q;
  assign bus.o_wb_adr   = {{(32-AW){1'b0}}, adr_q};
  assign bus.o_wb_dat   = dat_q;
  assign bus.o_wb_sel   = sel_q;
  assign bus.o_wb_we    = cyc_q;
  assign bus.o_wb_cyc   = cyc_q;
  assign o_cpu_rst      = cpu_rst_q;
  assign o_done         = done_q;
  assign o_err          = err_q;

endmodule
